seq_detect_ctrl: RTL and testbench

Programmable serial sequence-detector controller. It accepts a pattern configuration over a valid/ready handshake and sequences the detector through its idle, fill and run phases. While running it compares the incoming serial bit stream against the pattern, with or without overlap, counts matches in a saturating counter and pulses a match flag. It generalises the fixed "01" detector into a configurable, start/stop-controlled unit for the sequence_detector area.

---
 rtl/seq_detect_pkg.sv | 13 +
 rtl/seq_detect_ctrl_match_counter.sv | 22 ++
 rtl/seq_detect_ctrl.sv | 105 ++++++++++
 tb/tb_seq_detect_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// seq_detect_pkg: shared types and defaults for the serial sequence detector
package seq_detect_pkg;
    localparam int MAXLEN_DEF = 8;
    localparam int CNTW_DEF = 8;
    localparam int PAT_MAX = 16;
    localparam int LEN_W = 5;
    typedef enum logic [1:0] {IDLE, READY, FILL, RUN} state_t;
    typedef struct packed {
        logic [PAT_MAX-1:0] pattern;
        logic [LEN_W-1:0] len;
        logic overlap;
    } cfg_t;
endpackage

// File: rtl/seq_detect_ctrl_match_counter.sv
// match_counter: saturating match counter with synchronous clear
module match_counter #(
    parameter int CNTW = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic [CNTW-1:0] count,
    output logic sat
);
    localparam logic [CNTW-1:0] MAX = '1;
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            count <= '0;
            sat <= 1'b0;
        end else if (inc && !sat) begin
            count <= count + 1'b1;
            sat <= count == MAX - 1'b1;
        end
    end
endmodule

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: configurable serial pattern detector with start/stop control
module seq_detect_ctrl
    import seq_detect_pkg::*;
#(
    parameter int MAXLEN = MAXLEN_DEF,
    parameter int CNTW = CNTW_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic cfg_valid,
    output logic cfg_ready,
    input  logic [MAXLEN-1:0] cfg_pattern,
    input  logic [$clog2(MAXLEN+1)-1:0] cfg_len,
    input  logic cfg_overlap,
    input  logic start,
    input  logic stop,
    input  logic A,
    input  logic a_valid,
    output logic Y,
    output logic busy,
    output logic [CNTW-1:0] match_count,
    output logic count_sat,
    output logic err_cfg
);
    localparam int LW = $clog2(MAXLEN+1);
    state_t state, state_n;
    cfg_t cfg, cfg_n;
    logic err_n, y_n, hit, cfg_ok, clr, inc;
    logic [MAXLEN-1:0] hist, hist_n, shifted;
    logic [LW-1:0] fill, fill_n, fill_inc;
    logic [PAT_MAX-1:0] mask;
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cfg <= '0;
            err_cfg <= 1'b0;
            hist <= '0;
            fill <= '0;
            Y <= 1'b0;
            busy <= 1'b0;
            cfg_ready <= 1'b1;
        end else begin
            state <= state_n;
            cfg <= cfg_n;
            err_cfg <= err_n;
            hist <= hist_n;
            fill <= fill_n;
            Y <= y_n;
            busy <= state_n == FILL || state_n == RUN;
            cfg_ready <= state_n == IDLE || state_n == READY;
        end
    end
    always_comb begin
        state_n = state;
        cfg_n = cfg;
        err_n = err_cfg;
        hist_n = hist;
        fill_n = fill;
        y_n = 1'b0;
        clr = 1'b0;
        inc = 1'b0;
        cfg_ok = cfg_len != '0 && cfg_len <= LW'(MAXLEN);
        shifted = MAXLEN'({hist, A});
        fill_inc = fill == LW'(MAXLEN) ? fill : fill + 1'b1;
        mask = ~({PAT_MAX{1'b1}} << cfg.len);
        hit = fill_inc >= LW'(cfg.len) && ((PAT_MAX'(shifted) ^ cfg.pattern) & mask) == '0;
        if (state == IDLE || state == READY) begin
            if (cfg_valid) begin
                err_n = !cfg_ok;
                if (cfg_ok) begin
                    cfg_n = '{pattern: PAT_MAX'(cfg_pattern), len: LEN_W'(cfg_len), overlap: cfg_overlap};
                    state_n = READY;
                end
            end else if (start && state == READY) begin
                state_n = FILL;
                hist_n = '0;
                fill_n = '0;
                clr = 1'b1;
            end
        end else if (stop) begin
            state_n = READY;
        end else if (a_valid) begin
            hist_n = shifted;
            fill_n = fill_inc;
            state_n = fill_inc >= LW'(cfg.len) ? RUN : FILL;
            if (hit) begin
                y_n = 1'b1;
                inc = 1'b1;
                // non-overlapping mode demands len fresh bits before the next match
                if (!cfg.overlap) begin
                    fill_n = '0;
                    state_n = FILL;
                end
            end
        end
    end
    match_counter #(.CNTW(CNTW)) u_cnt (
        .clk(clk),
        .rst(rst),
        .clr(clr),
        .inc(inc),
        .count(match_count),
        .sat(count_sat)
    );
endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb_seq_detect_ctrl: randomized and directed checks against a bit-queue reference model
module tb_seq_detect_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic cfg_valid = 1'b0, cfg_overlap = 1'b0, start = 1'b0, stop = 1'b0, A = 1'b0, a_valid = 1'b0;
    logic [7:0] cfg_pattern = '0;
    logic [3:0] cfg_len = '0;
    logic cfg_ready, y, busy, sat, err;
    logic cfg_ready2, y2, busy2, sat2, err2;
    logic [7:0] mc;
    logic [1:0] mc2;
    int checks = 0, errors = 0;
    bit m_held, m_act, m_y, m_err, m_ovl;
    int m_len, c8, c2;
    logic [7:0] m_pat;
    bit q[$];
    always #5 clk = ~clk;
    seq_detect_ctrl #(.MAXLEN(8), .CNTW(8)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .start(start), .stop(stop), .A(A), .a_valid(a_valid), .Y(y), .busy(busy),
        .match_count(mc), .count_sat(sat), .err_cfg(err)
    );
    seq_detect_ctrl #(.MAXLEN(8), .CNTW(2)) dut2 (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready2),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .start(start), .stop(stop), .A(A), .a_valid(a_valid), .Y(y2), .busy(busy2),
        .match_count(mc2), .count_sat(sat2), .err_cfg(err2)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic bit tail_match();
        int n = q.size();
        if (n < m_len) return 1'b0;
        for (int i = 0; i < m_len; i++)
            if (q[n-m_len+i] != m_pat[m_len-1-i]) return 1'b0;
        return 1'b1;
    endfunction
    task automatic model();
        m_y = 1'b0;
        if (!rst) begin
            m_held = 0; m_act = 0; m_err = 0; m_ovl = 0;
            m_len = 0; m_pat = '0; c8 = 0; c2 = 0;
            q.delete();
        end else if (!m_act) begin
            if (cfg_valid) begin
                m_err = !(cfg_len >= 1 && cfg_len <= 8);
                if (!m_err) begin
                    m_held = 1; m_pat = cfg_pattern; m_len = int'(cfg_len); m_ovl = cfg_overlap;
                end
            end else if (start && m_held) begin
                m_act = 1; c8 = 0; c2 = 0;
                q.delete();
            end
        end else if (stop) begin
            m_act = 0;
        end else if (a_valid) begin
            q.push_back(A);
            if (q.size() > 8) void'(q.pop_front());
            if (tail_match()) begin
                m_y = 1;
                c8 = c8 < 255 ? c8 + 1 : 255;
                c2 = c2 < 3 ? c2 + 1 : 3;
                if (!m_ovl) q.delete();
            end
        end
    endtask
    task automatic step();
        @(posedge clk);
        model();
        #1;
        check("Y", y, m_y);
        check("busy", busy, m_act);
        check("cfg_ready", cfg_ready, !m_act);
        check("count", mc, c8);
        check("sat", sat, c8 == 255);
        check("err", err, m_err);
        check("Y2", y2, m_y);
        check("busy2", busy2, m_act);
        check("count2", mc2, c2);
        check("sat2", sat2, c2 == 3);
        check("err2", err2, m_err);
        check("cfg_ready2", cfg_ready2, !m_act);
    endtask
    task automatic clr_in();
        cfg_valid = 0; start = 0; stop = 0; a_valid = 0; A = 0;
    endtask
    task automatic config_in(input logic [7:0] p, input int l, input bit o);
        clr_in();
        cfg_valid = 1; cfg_pattern = p; cfg_len = 4'(l); cfg_overlap = o;
        step();
        cfg_valid = 0;
    endtask
    task automatic go();
        start = 1; step(); start = 0;
    endtask
    task automatic bit_in(input bit b);
        a_valid = 1; A = b; step(); a_valid = 0;
    endtask
    task automatic halt();
        stop = 1; step(); stop = 0;
    endtask
    task automatic bits(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) bit_in(v[i]);
    endtask
    initial begin
        clr_in();
        rst = 0; step(); step();
        check("rst_ready", cfg_ready, 1);
        rst = 1; step();
        config_in(8'b01, 2, 0); go();
        bits(16'b010011, 6);
        check("tp1_count", mc, 2);
        halt();
        config_in(8'b101, 3, 1); go();
        bits(16'b10101, 5);
        check("tp2_ovl_count", mc, 2);
        halt();
        config_in(8'b101, 3, 0); go();
        bits(16'b10101, 5);
        check("tp2_noovl_count", mc, 1);
        halt();
        config_in(8'b1, 1, 1); go();
        bits(16'b111111, 6);
        check("tp3_count2", mc2, 3);
        check("tp3_sat2", sat2, 1);
        check("tp3_count", mc, 6);
        halt();
        rst = 0; step(); rst = 1;
        config_in(8'b0, 0, 0);
        check("tp4_err0", err, 1);
        config_in(8'b0, 9, 0);
        check("tp4_err9", err, 1);
        go();
        check("tp4_start_ignored", busy, 0);
        config_in(8'b01, 2, 0);
        check("tp4_err_clear", err, 0);
        go();
        bits(16'b01, 2);
        check("tp5_match", mc, 1);
        a_valid = 1; A = 0; rst = 0; step(); rst = 1; a_valid = 0;
        check("tp5_rst_count", mc, 0);
        check("tp5_rst_ready", cfg_ready, 1);
        go();
        check("tp5_start_ignored", busy, 0);
        config_in(8'b01, 2, 0); go();
        bit_in(0);
        stop = 1; a_valid = 1; A = 1; step(); clr_in();
        check("tp6_no_y", y, 0);
        check("tp6_count", mc, 0);
        check("tp6_busy", busy, 0);
        check("tp6_ready", cfg_ready, 1);
        for (int i = 0; i < 3000; i++) begin
            rst = $urandom_range(0, 299) != 0;
            cfg_valid = $urandom_range(0, 9) == 0;
            cfg_len = $urandom_range(0, 3) == 0 ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 3));
            cfg_pattern = 8'($urandom);
            cfg_overlap = 1'($urandom);
            start = $urandom_range(0, 7) == 0;
            stop = $urandom_range(0, 39) == 0;
            a_valid = $urandom_range(0, 3) != 0;
            A = 1'($urandom);
            step();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
